// File: rtl/sd_cmd_pkg.sv
// Shared types and frame widths for the SD command-layer master.
package sd_cmd_pkg;

  localparam int CMD_INDEX_W = 6;
  localparam int CMD_ARG_W   = 32;
  localparam int CMD_FRAME_W = CMD_INDEX_W + CMD_ARG_W;

  // Command sequencing phases: issue, wait for the PHY to take the frame,
  // wait for the response, then hold results until the host lets go.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } cmd_state_e;

endpackage

// File: rtl/sd_cmd_master.sv
// SD command-layer master: packs {index, argument} for the CMD physical
// layer, runs the two REQ/ACK handshakes and reports status to the host.
module sd_cmd_master
  import sd_cmd_pkg::*;
(
  input  logic                   CLK_host,
  input  logic                   reset,
  input  logic                   new_cmd,
  input  logic                   ACK_in,
  input  logic                   REQ_in,
  input  logic                   physical_waiting_cmd,
  input  logic [CMD_ARG_W-1:0]   cmd_arg,
  input  logic [CMD_INDEX_W-1:0] cmd_index,
  input  logic [CMD_FRAME_W-1:0] cmd_response,
  input  logic                   timeout_error_from_physical,
  output logic                   cmd_busy,
  output logic                   cmd_complete,
  output logic                   REQ_out,
  output logic                   ACK_out,
  output logic                   timeout_error,
  output logic [CMD_ARG_W-1:0]   response_arg,
  output logic [CMD_INDEX_W-1:0] response_index,
  output logic [CMD_FRAME_W-1:0] cmd_to_physical
);

  cmd_state_e             state_q, state_d;
  logic                   cmd_busy_q, cmd_busy_d;
  logic                   cmd_complete_q, cmd_complete_d;
  logic                   req_out_q, req_out_d;
  logic                   ack_out_q, ack_out_d;
  logic                   timeout_error_q, timeout_error_d;
  logic [CMD_ARG_W-1:0]   response_arg_q, response_arg_d;
  logic [CMD_INDEX_W-1:0] response_index_q, response_index_d;
  logic [CMD_FRAME_W-1:0] cmd_frame_q, cmd_frame_d;

  // The PHY idle flag is reserved; it deliberately gates nothing.
  logic unused_physical_waiting;
  assign unused_physical_waiting = physical_waiting_cmd;

  // Next-state and next-output decode; everything holds unless a phase moves on.
  always_comb begin
    state_d          = state_q;
    cmd_busy_d       = cmd_busy_q;
    cmd_complete_d   = cmd_complete_q;
    req_out_d        = req_out_q;
    ack_out_d        = ack_out_q;
    timeout_error_d  = timeout_error_q;
    response_arg_d   = response_arg_q;
    response_index_d = response_index_q;
    cmd_frame_d      = cmd_frame_q;

    unique case (state_q)
      IDLE: begin
        if (new_cmd) begin
          cmd_frame_d     = {cmd_index, cmd_arg};
          req_out_d       = 1'b1;
          cmd_busy_d      = 1'b1;
          cmd_complete_d  = 1'b0;
          timeout_error_d = 1'b0;
          state_d         = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (timeout_error_from_physical) begin
          timeout_error_d = 1'b1;
          cmd_complete_d  = 1'b1;
          cmd_busy_d      = 1'b0;
          req_out_d       = 1'b0;
          state_d         = DONE;
        end else if (ACK_in) begin
          req_out_d = 1'b0;
          state_d   = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (timeout_error_from_physical) begin
          timeout_error_d = 1'b1;
          cmd_complete_d  = 1'b1;
          cmd_busy_d      = 1'b0;
          req_out_d       = 1'b0;
          state_d         = DONE;
        end else if (REQ_in) begin
          response_index_d = cmd_response[CMD_FRAME_W-1:CMD_ARG_W];
          response_arg_d   = cmd_response[CMD_ARG_W-1:0];
          ack_out_d        = 1'b1;
          cmd_complete_d   = 1'b1;
          cmd_busy_d       = 1'b0;
          state_d          = DONE;
        end
      end

      DONE: begin
        // ACK follows REQ down; a held-high new_cmd keeps us parked here.
        ack_out_d = ack_out_q & REQ_in;
        if (!REQ_in && !new_cmd) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      state_q          <= IDLE;
      cmd_busy_q       <= 1'b0;
      cmd_complete_q   <= 1'b0;
      req_out_q        <= 1'b0;
      ack_out_q        <= 1'b0;
      timeout_error_q  <= 1'b0;
      response_arg_q   <= '0;
      response_index_q <= '0;
      cmd_frame_q      <= '0;
    end else begin
      state_q          <= state_d;
      cmd_busy_q       <= cmd_busy_d;
      cmd_complete_q   <= cmd_complete_d;
      req_out_q        <= req_out_d;
      ack_out_q        <= ack_out_d;
      timeout_error_q  <= timeout_error_d;
      response_arg_q   <= response_arg_d;
      response_index_q <= response_index_d;
      cmd_frame_q      <= cmd_frame_d;
    end
  end

  assign cmd_busy        = cmd_busy_q;
  assign cmd_complete    = cmd_complete_q;
  assign REQ_out         = req_out_q;
  assign ACK_out         = ack_out_q;
  assign timeout_error   = timeout_error_q;
  assign response_arg    = response_arg_q;
  assign response_index  = response_index_q;
  assign cmd_to_physical = cmd_frame_q;

endmodule

// File: tb/tb_sd_cmd_master.sv
// Self-checking bench for sd_cmd_master: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_sd_cmd_master;

  logic        clk;
  logic        reset;
  logic        newCmd;
  logic        ackIn;
  logic        reqIn;
  logic        physWaiting;
  logic [31:0] cmdArg;
  logic [5:0]  cmdIndex;
  logic [37:0] cmdResponse;
  logic        timeoutIn;
  logic        cmdBusy;
  logic        cmdComplete;
  logic        reqOut;
  logic        ackOut;
  logic        timeoutError;
  logic [31:0] responseArg;
  logic [5:0]  responseIndex;
  logic [37:0] cmdToPhysical;

  int checkCount;
  int passCount;

  // Reference model: command lifecycle tracked as flags, not as an encoded FSM.
  bit          mInFlight;
  bit          mAwaitAck;
  bit          mFinished;
  bit          mBusy;
  bit          mComplete;
  bit          mReq;
  bit          mAck;
  bit          mTimeout;
  logic [31:0] mRespArg;
  logic [5:0]  mRespIndex;
  logic [37:0] mFrame;

  sd_cmd_master dut (
    .CLK_host                    (clk),
    .reset                       (reset),
    .new_cmd                     (newCmd),
    .ACK_in                      (ackIn),
    .REQ_in                      (reqIn),
    .physical_waiting_cmd        (physWaiting),
    .cmd_arg                     (cmdArg),
    .cmd_index                   (cmdIndex),
    .cmd_response                (cmdResponse),
    .timeout_error_from_physical (timeoutIn),
    .cmd_busy                    (cmdBusy),
    .cmd_complete                (cmdComplete),
    .REQ_out                     (reqOut),
    .ACK_out                     (ackOut),
    .timeout_error               (timeoutError),
    .response_arg                (responseArg),
    .response_index              (responseIndex),
    .cmd_to_physical             (cmdToPhysical)
  );

  // Free-running host clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Advance the model one clock using the inputs sampled at that edge.
  task automatic modelStep();
    if (reset) begin
      mInFlight = 0; mAwaitAck = 0; mFinished = 0;
      mBusy = 0; mComplete = 0; mReq = 0; mAck = 0; mTimeout = 0;
      mRespArg = '0; mRespIndex = '0; mFrame = '0;
    end else if (mInFlight) begin
      if (timeoutIn) begin
        mTimeout = 1; mComplete = 1; mBusy = 0; mReq = 0;
        mInFlight = 0; mFinished = 1;
      end else if (mAwaitAck) begin
        if (ackIn) begin
          mReq = 0; mAwaitAck = 0;
        end
      end else if (reqIn) begin
        mRespIndex = cmdResponse[37:32];
        mRespArg   = cmdResponse[31:0];
        mAck = 1; mComplete = 1; mBusy = 0;
        mInFlight = 0; mFinished = 1;
      end
    end else if (mFinished) begin
      mAck = mAck && reqIn;
      if (!reqIn && !newCmd) mFinished = 0;
    end else if (newCmd) begin
      mFrame = {cmdIndex, cmdArg};
      mReq = 1; mBusy = 1; mComplete = 0; mTimeout = 0;
      mInFlight = 1; mAwaitAck = 1;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compareAll();
    checkOutput("cmd_busy",        64'(cmdBusy),       64'(mBusy));
    checkOutput("cmd_complete",    64'(cmdComplete),   64'(mComplete));
    checkOutput("REQ_out",         64'(reqOut),        64'(mReq));
    checkOutput("ACK_out",         64'(ackOut),        64'(mAck));
    checkOutput("timeout_error",   64'(timeoutError),  64'(mTimeout));
    checkOutput("response_arg",    64'(responseArg),   64'(mRespArg));
    checkOutput("response_index",  64'(responseIndex), 64'(mRespIndex));
    checkOutput("cmd_to_physical", 64'(cmdToPhysical), 64'(mFrame));
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked mid-cycle.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1; newCmd = 0; ackIn = 0; reqIn = 0; physWaiting = 0;
    cmdArg = '0; cmdIndex = '0; cmdResponse = '0; timeoutIn = 0;
    @(negedge clk);

    // Reset held for two cycles.
    applyStimulus();
    applyStimulus();
    checkOutput("reset_busy",  64'(cmdBusy),       64'd0);
    checkOutput("reset_frame", 64'(cmdToPhysical), 64'd0);
    reset = 0;

    // Basic command issue.
    newCmd = 1; cmdIndex = 6'h3F; cmdArg = 32'hAAAA_AAAA; physWaiting = 1;
    applyStimulus();
    checkOutput("issue_frame", 64'(cmdToPhysical), 64'h3F_AAAA_AAAA);
    checkOutput("issue_req",   64'(reqOut),        64'd1);
    checkOutput("issue_busy",  64'(cmdBusy),       64'd1);

    // REQ_in during WAIT_ACK must be ignored.
    newCmd = 0; reqIn = 1; cmdResponse = 38'h15_1234_5678;
    applyStimulus();
    checkOutput("waitack_ack_out",  64'(ackOut),        64'd0);
    checkOutput("waitack_no_capt",  64'(responseIndex), 64'd0);

    // PHY accepts the frame.
    reqIn = 0; ackIn = 1;
    applyStimulus();
    checkOutput("acked_req",   64'(reqOut),        64'd0);
    checkOutput("acked_frame", 64'(cmdToPhysical), 64'h3F_AAAA_AAAA);

    // new_cmd pulse in WAIT_RESP is ignored.
    ackIn = 0; newCmd = 1; cmdIndex = 6'h01; cmdArg = 32'h0;
    applyStimulus();
    checkOutput("ignored_frame", 64'(cmdToPhysical), 64'h3F_AAAA_AAAA);
    checkOutput("ignored_busy",  64'(cmdBusy),       64'd1);
    newCmd = 0;

    // Response capture.
    cmdResponse = 38'b111001_0111_0110_0101_0100_0011_0010_0001_0000;
    reqIn = 1;
    applyStimulus();
    checkOutput("resp_index",    64'(responseIndex), 64'h39);
    checkOutput("resp_arg",      64'(responseArg),   64'h7654_3210);
    checkOutput("resp_ack",      64'(ackOut),        64'd1);
    checkOutput("resp_complete", 64'(cmdComplete),   64'd1);
    checkOutput("resp_busy",     64'(cmdBusy),       64'd0);

    // Everything held high: parked in DONE, no reissue.
    newCmd = 1; ackIn = 1; cmdIndex = 6'h22; cmdArg = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("held_req", 64'(reqOut), 64'd0);
      checkOutput("held_ack", 64'(ackOut), 64'd1);
    end
    reqIn = 0; ackIn = 0;
    applyStimulus();
    checkOutput("drop_req_ack", 64'(ackOut), 64'd0);
    applyStimulus();
    checkOutput("still_done_req", 64'(reqOut), 64'd0);
    newCmd = 0;
    applyStimulus();

    // New command, then timeout in WAIT_RESP racing a REQ_in.
    newCmd = 1; cmdIndex = 6'h05; cmdArg = 32'h1111_2222;
    applyStimulus();
    checkOutput("cmd2_req", 64'(reqOut), 64'd1);
    newCmd = 0; ackIn = 1;
    applyStimulus();
    ackIn = 0; reqIn = 1; timeoutIn = 1; cmdResponse = 38'h0A_CAFE_F00D;
    applyStimulus();
    checkOutput("to_flag",     64'(timeoutError),  64'd1);
    checkOutput("to_complete", 64'(cmdComplete),   64'd1);
    checkOutput("to_keep_idx", 64'(responseIndex), 64'h39);
    checkOutput("to_keep_arg", 64'(responseArg),   64'h7654_3210);
    checkOutput("to_no_ack",   64'(ackOut),        64'd0);
    timeoutIn = 0; reqIn = 0;
    applyStimulus();
    newCmd = 1; cmdIndex = 6'h07;
    applyStimulus();
    checkOutput("to_cleared",       64'(timeoutError), 64'd0);
    checkOutput("complete_cleared", 64'(cmdComplete),  64'd0);

    // Reset asserted mid-command in WAIT_RESP.
    newCmd = 0; ackIn = 1;
    applyStimulus();
    ackIn = 0; reset = 1;
    applyStimulus();
    checkOutput("midreset_busy",  64'(cmdBusy),       64'd0);
    checkOutput("midreset_frame", 64'(cmdToPhysical), 64'd0);
    checkOutput("midreset_resp",  64'(responseArg),   64'd0);
    reset = 0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      newCmd      = $urandom_range(0, 1);
      ackIn       = ($urandom_range(0, 2) == 0);
      reqIn       = ($urandom_range(0, 2) == 0);
      timeoutIn   = ($urandom_range(0, 19) == 0);
      physWaiting = $urandom_range(0, 1);
      cmdIndex    = 6'($urandom);
      cmdArg      = $urandom;
      cmdResponse = {6'($urandom), 32'($urandom)};
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sd_cmd_master.md
Name: sd_cmd_master

Overview:
- Command-layer master of the SD host controller. Sits between the host register file (new_cmd, cmd_index, cmd_arg) and the CMD physical layer.
- Packs a 38-bit command frame {index, argument} and hands it to the physical layer with a REQ/ACK handshake.
- Accepts the 38-bit response from the physical layer with a second REQ/ACK handshake, unpacks it to index and argument, and reports busy, complete and timeout status to the host.

Parameters:
- none. Frame widths are fixed constants: index 6, argument 32, frame 38.

Ports:
- CLK_host  in  1  host clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- new_cmd  in  1  level request from host to issue a command
- ACK_in  in  1  physical layer has accepted cmd_to_physical
- REQ_in  in  1  physical layer presents a valid response on cmd_response
- physical_waiting_cmd  in  1  physical layer idle status; reserved, no functional effect in this revision
- cmd_arg  in  32  command argument
- cmd_index  in  6  command index
- cmd_response  in  38  response frame from physical layer: [37:32] index, [31:0] argument
- timeout_error_from_physical  in  1  physical layer response timeout
- cmd_busy  out  1  command in flight
- cmd_complete  out  1  command finished, with response or with timeout
- REQ_out  out  1  cmd_to_physical is valid; request to physical layer
- ACK_out  out  1  response captured; acknowledge to physical layer
- timeout_error  out  1  latched timeout status
- response_arg  out  32  captured response argument
- response_index  out  6  captured response index
- cmd_to_physical  out  38  command frame: {cmd_index, cmd_arg}

Behaviour:
- Interface: one clock, CLK_host. reset is synchronous and active-high. All outputs are registered.
- On reset: state goes to IDLE and every output is 0. This applies from any state, including mid-command.
- State machine: IDLE, WAIT_ACK, WAIT_RESP, DONE.
- IDLE, new_cmd=1 at an edge:
  - cmd_to_physical <= {cmd_index, cmd_arg}
  - REQ_out <= 1, cmd_busy <= 1
  - cmd_complete <= 0, timeout_error <= 0
  - go to WAIT_ACK. Outputs are visible 1 cycle after the sampling edge.
- WAIT_ACK:
  - ACK_in=1: REQ_out <= 0, go to WAIT_RESP. cmd_to_physical holds its value.
  - REQ_in is ignored in this state.
- WAIT_RESP, REQ_in=1:
  - response_index <= cmd_response[37:32], response_arg <= cmd_response[31:0]
  - ACK_out <= 1, cmd_complete <= 1, cmd_busy <= 0
  - go to DONE.
- Timeout: timeout_error_from_physical=1 in WAIT_ACK or WAIT_RESP:
  - timeout_error <= 1, cmd_complete <= 1, cmd_busy <= 0, REQ_out <= 0
  - response registers unchanged; go to DONE.
  - Timeout has priority over a simultaneous ACK_in or REQ_in.
- DONE:
  - ACK_out stays 1 while REQ_in=1 and drops to 0 when REQ_in=0.
  - Return to IDLE when REQ_in=0 and new_cmd=0. A held-high new_cmd therefore never reissues a command.
  - cmd_complete, timeout_error and response registers stay valid until the next command is accepted.
- new_cmd outside IDLE is ignored; there is no queuing.
- physical_waiting_cmd never gates any transition.

Decomposition:
- Shared package sd_cmd_pkg:
  - state enum {IDLE, WAIT_ACK, WAIT_RESP, DONE}
  - CMD_INDEX_W=6, CMD_ARG_W=32, CMD_FRAME_W=38
- A single module; no sub-module is needed. The frame pack and unpack are plain slices.

Test Plan:
- Reset: hold reset 2 cycles -> all outputs 0, state IDLE. Assert reset in WAIT_RESP -> all outputs 0 on the next edge.
- Basic command:
  - new_cmd=1, cmd_index=6'h3F, cmd_arg=32'hAAAA_AAAA -> next cycle cmd_to_physical=38'h3F_AAAA_AAAA, REQ_out=1, cmd_busy=1.
  - ACK_in=1 -> REQ_out=0.
- Response capture: cmd_response=38'b111001_0111_0110_0101_0100_0011_0010_0001_0000, REQ_in=1 -> response_index=6'h39, response_arg=32'h7654_3210, ACK_out=1, cmd_complete=1, cmd_busy=0.
- Held inputs: new_cmd, ACK_in and REQ_in all left high after completion -> stays in DONE with no second REQ_out. Drop REQ_in -> ACK_out=0. Drop new_cmd -> IDLE.
- Timeout: timeout_error_from_physical=1 in WAIT_RESP, together with REQ_in=1 -> timeout_error=1, cmd_complete=1, response registers unchanged. Next accepted command clears timeout_error.
- Ignored inputs: REQ_in=1 during WAIT_ACK -> no capture, ACK_out stays 0. new_cmd pulse during WAIT_RESP -> ignored.
